sha2_compress_iter: RTL and testbench
=====================================

Name: sha2_compress_iter

Overview:
- Iterative SHA-2 compression engine, parametrised for SHA-256 (32-bit words, 64 rounds) or SHA-512 (64-bit words, 80 rounds).
- Executes one round per accepted W/K beat, using Σ0, Σ1, Ch and Maj on working variables a..h.
- Adds the final working variables back into the chaining value.
- Sits between the message-schedule unit (source of W_t) and the digest/padding controller (source of the chaining value and start).

Parameters:
- WORD_W, 32, word width; legal values 32 or 64.
- ROUNDS, 64, rounds per block; must be 64 when WORD_W=32 and 80 when WORD_W=64.
- CNT_W, 7, round-counter width; must satisfy 2^CNT_W > ROUNDS.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a block; ignored unless the engine is idle.
- hash_in  in  8*WORD_W  chaining value H0..H7; H0 (a) in the MSBs [8W-1:7W].
- busy  out  1  high from the cycle after an accepted start until done.
- wk_valid  in  1  W_t/K_t beat valid.
- w_in  in  WORD_W  message-schedule word W_t.
- k_in  in  WORD_W  round constant K_t.
- wk_ready  out  1  engine can accept a round beat this cycle.
- done  out  1  one-cycle pulse; hash_out is valid in this cycle.
- hash_out  out  8*WORD_W  updated chaining value, same packing as hash_in; held until the next done.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, round counter=0, a..h=0, stored H=0, hash_out=0, busy=0, wk_ready=0, done=0.
- States:
  - IDLE: start=1 latches hash_in into H and into a..h; counter=0; go to ROUND.
  - ROUND: wk_ready=1. When wk_valid&wk_ready, perform one round:
    - T1 = h + Σ1(e) + Ch(e,f,g) + k_in + w_in
    - T2 = Σ0(a) + Maj(a,b,c)
    - h=g, g=f, f=e, e=d+T1, d=c, c=b, b=a, a=T1+T2
    - counter increments.
    - A beat that also has counter==ROUNDS-1 moves to FINAL.
    - wk_valid=0 stalls: all registers hold, with no limit on stall length.
  - FINAL: wk_ready=0; hash_out word i = H_i + var_i mod 2^WORD_W; go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0; return to IDLE.
- Rotation constants:
  - WORD_W=32: Σ0 = ROTR2^ROTR13^ROTR22; Σ1 = ROTR6^ROTR11^ROTR25.
  - WORD_W=64: Σ0 = ROTR28^ROTR34^ROTR39; Σ1 = ROTR14^ROTR18^ROTR41.
- Arithmetic: all additions mod 2^WORD_W; carries are discarded.
- Latency: start to done = ROUNDS + 2 cycles after the start cycle, when wk_valid is held high.
- busy is high in ROUND and FINAL.
- start while busy or in DONE: ignored and not queued.
- wk_valid outside ROUND: ignored; wk_ready is 0 there.
- rst_n asserted mid-block: immediate return to reset values; the partial block is discarded.
- hash_out changes only at the FINAL→DONE edge.
- Illegal WORD_W/ROUNDS combination: elaboration-time error.

Decomposition:
- Shared package sha2_pkg holds:
  - rotation-amount constants per word width (SIG0_R0/R1/R2, SIG1_R0/R1/R2 for 256 and 512);
  - ROUNDS_256=64, ROUNDS_512=80;
  - state encoding IDLE/ROUND/FINAL/DONE.
- One sub-module: sha2_big_sigma.
  - Parametrised by WORD_W and three rotate amounts; combinational ROTR-XOR.
  - Instantiated twice, once as Σ0 and once as Σ1.
- Ch, Maj and the adders stay inline.

Test Plan:
- Σ unit, WORD_W=32: x=0x00000001 → Σ0=0x40080400 and Σ1=0x04200080; x=0xFFFFFFFF → both 0xFFFFFFFF.
- SHA-256 "abc":
  - Stimulus: IV 6a09e667…5be0cd19, padded block, W_t from the bench model, K_t standard, wk_valid held high.
  - Required: done exactly 66 cycles after start; hash_out = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- SHA-512 "abc" (WORD_W=64, ROUNDS=80):
  - Required: done 82 cycles after start.
  - hash_out begins ddaf35a193617aba cc417349ae204131 and ends a54ca49f.
- Stalls:
  - Stimulus: the "abc" SHA-256 block with wk_valid randomly low (≈50%).
  - Required: the same digest; done = start + 2 + number of accepted-beat cycles + stall cycles; a..h unchanged on stall cycles.
- Start while busy:
  - Stimulus: start pulsed at round 10 with a different hash_in.
  - Required: ignored; the digest equals the no-pulse result; exactly one done pulse.
- Reset mid-block:
  - Stimulus: rst_n low at round 30 for 1 cycle, then a fresh "abc" block.
  - Required: busy=0, done=0, hash_out=0 immediately at reset; the following block yields the correct digest.

Source files
------------

// File: rtl/sha2_pkg.sv
// Shared SHA-2 definitions: round counts, Sigma rotate amounts, FSM encoding.
package sha2_pkg;

    localparam int ROUNDS_256 = 64;
    localparam int ROUNDS_512 = 80;

    // Big-sigma rotate amounts, SHA-256 (32-bit words)
    localparam int SIG0_R0_256 = 2;
    localparam int SIG0_R1_256 = 13;
    localparam int SIG0_R2_256 = 22;
    localparam int SIG1_R0_256 = 6;
    localparam int SIG1_R1_256 = 11;
    localparam int SIG1_R2_256 = 25;

    // Big-sigma rotate amounts, SHA-512 (64-bit words)
    localparam int SIG0_R0_512 = 28;
    localparam int SIG0_R1_512 = 34;
    localparam int SIG0_R2_512 = 39;
    localparam int SIG1_R0_512 = 14;
    localparam int SIG1_R1_512 = 18;
    localparam int SIG1_R2_512 = 41;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/sha2_compress_iter_if.sv
// Bus between the compression engine, its message-schedule source and the digest controller.
interface sha2_compress_iter_if #(
    parameter int WORD_W = 32
);
    logic                  start;
    logic [8*WORD_W-1:0]   hash_in;
    logic                  busy;
    logic                  wk_valid;
    logic [WORD_W-1:0]     w_in;
    logic [WORD_W-1:0]     k_in;
    logic                  wk_ready;
    logic                  done;
    logic [8*WORD_W-1:0]   hash_out;

    // Requester side: controller plus schedule unit
    modport master (
        output start, hash_in, wk_valid, w_in, k_in,
        input  busy, wk_ready, done, hash_out
    );

    // Engine side
    modport slave (
        input  start, hash_in, wk_valid, w_in, k_in,
        output busy, wk_ready, done, hash_out
    );
endinterface

// File: rtl/sha2_big_sigma.sv
// Combinational big-sigma: XOR of three right-rotations of one word.
module sha2_big_sigma #(
    parameter int WORD_W = 32,
    parameter int R0     = 2,
    parameter int R1     = 13,
    parameter int R2     = 22
) (
    input  logic [WORD_W-1:0] x,
    output logic [WORD_W-1:0] y
);

    // Doubling the word turns every rotate into a plain constant slice
    logic [2*WORD_W-1:0] xx;

    assign xx = {x, x};
    assign y  = xx[R0 +: WORD_W] ^ xx[R1 +: WORD_W] ^ xx[R2 +: WORD_W];

endmodule

// File: rtl/sha2_compress_iter.sv
// Iterative SHA-256/SHA-512 compression: one round per accepted W/K beat,
// then the working variables are folded back into the chaining value.
module sha2_compress_iter
    import sha2_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int ROUNDS = 64,
    parameter int CNT_W  = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sha2_compress_iter_if.slave  bus
);

    localparam bool_wide = (WORD_W == 64);
    localparam int S0_R0 = bool_wide ? SIG0_R0_512 : SIG0_R0_256;
    localparam int S0_R1 = bool_wide ? SIG0_R1_512 : SIG0_R1_256;
    localparam int S0_R2 = bool_wide ? SIG0_R2_512 : SIG0_R2_256;
    localparam int S1_R0 = bool_wide ? SIG1_R0_512 : SIG1_R0_256;
    localparam int S1_R1 = bool_wide ? SIG1_R1_512 : SIG1_R1_256;
    localparam int S1_R2 = bool_wide ? SIG1_R2_512 : SIG1_R2_256;

    // Reject configurations that are not SHA-256 or SHA-512, or a counter too narrow
    if (!((WORD_W == 32 && ROUNDS == ROUNDS_256) || (WORD_W == 64 && ROUNDS == ROUNDS_512))
        || ((2 ** CNT_W) <= ROUNDS)) begin : g_cfg_err
        $error("sha2_compress_iter: illegal WORD_W/ROUNDS/CNT_W combination");
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WORD_W-1:0]  var_q  [8];    // a..h working variables
    logic [WORD_W-1:0]  var_d  [8];
    logic [WORD_W-1:0]  h_q    [8];    // chaining value captured at start
    logic [WORD_W-1:0]  h_d    [8];
    logic [WORD_W-1:0]  hout_q [8];
    logic [WORD_W-1:0]  hout_d [8];
    logic [WORD_W-1:0]  hin_w  [8];

    logic [WORD_W-1:0]  sig0, sig1, ch, maj, t1, t2;
    logic               beat;
    logic               last_cnt;

    // Word 0 (a / H0) lives in the most significant slice of the packed buses
    for (genvar gi = 0; gi < 8; gi++) begin : g_pack
        assign hin_w[gi] = bus.hash_in[(8-gi)*WORD_W-1 -: WORD_W];
        assign bus.hash_out[(8-gi)*WORD_W-1 -: WORD_W] = hout_q[gi];
    end

    sha2_big_sigma #(.WORD_W(WORD_W), .R0(S0_R0), .R1(S0_R1), .R2(S0_R2)) u_sigma0 (
        .x (var_q[0]),
        .y (sig0)
    );

    sha2_big_sigma #(.WORD_W(WORD_W), .R0(S1_R0), .R1(S1_R1), .R2(S1_R2)) u_sigma1 (
        .x (var_q[4]),
        .y (sig1)
    );

    // Round function terms; all sums wrap modulo 2^WORD_W
    always_comb begin
        ch       = (var_q[4] & var_q[5]) ^ (~var_q[4] & var_q[6]);
        maj      = (var_q[0] & var_q[1]) ^ (var_q[0] & var_q[2]) ^ (var_q[1] & var_q[2]);
        t1       = var_q[7] + sig1 + ch + bus.k_in + bus.w_in;
        t2       = sig0 + maj;
        beat     = (state_q == ROUND) && bus.wk_valid;
        last_cnt = (cnt_q == CNT_W'(ROUNDS - 1));
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = ROUND;
            ROUND:   if (beat && last_cnt) state_d = FINAL;
            FINAL:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the current state
    always_comb begin
        bus.busy     = (state_q == ROUND) || (state_q == FINAL);
        bus.wk_ready = (state_q == ROUND);
        bus.done     = (state_q == DONE);
    end

    // Datapath next values: load at start, shift a..h per beat, fold in at FINAL
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < 8; i++) begin
            var_d[i]  = var_q[i];
            h_d[i]    = h_q[i];
            hout_d[i] = hout_q[i];
        end
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    cnt_d = '0;
                    for (int i = 0; i < 8; i++) begin
                        var_d[i] = hin_w[i];
                        h_d[i]   = hin_w[i];
                    end
                end
            end
            ROUND: begin
                if (beat) begin
                    var_d[7] = var_q[6];
                    var_d[6] = var_q[5];
                    var_d[5] = var_q[4];
                    var_d[4] = var_q[3] + t1;
                    var_d[3] = var_q[2];
                    var_d[2] = var_q[1];
                    var_d[1] = var_q[0];
                    var_d[0] = t1 + t2;
                    cnt_d    = cnt_q + 1'b1;
                end
            end
            FINAL: begin
                for (int i = 0; i < 8; i++) begin
                    hout_d[i] = h_q[i] + var_q[i];
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            for (int i = 0; i < 8; i++) begin
                var_q[i]  <= '0;
                h_q[i]    <= '0;
                hout_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            for (int i = 0; i < 8; i++) begin
                var_q[i]  <= var_d[i];
                h_q[i]    <= h_d[i];
                hout_q[i] <= hout_d[i];
            end
        end
    end

endmodule

// File: tb/tb_sha2_compress_iter.sv
// Bench for sha2_compress_iter: sigma spot values, SHA-256/512 "abc" blocks,
// random stalls, start while busy and reset mid-block, scoreboard on done.
module tb_sha2_compress_iter;

    localparam logic [255:0] IV256 =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [511:0] IV512 =
        512'h6a09e667f3bcc908bb67ae8584caa73b3c6ef372fe94f82ba54ff53a5f1d36f1510e527fade682d19b05688c2b3e6c1f1f83d9abfb41bd6b5be0cd19137e2179;
    localparam logic [255:0] D256 =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [511:0] D512 =
        512'hddaf35a193617abacc417349ae20413112e6fa4e89a97ea20a9eeee64b55d39a2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sha2_compress_iter_if #(.WORD_W(32)) if32 ();
    sha2_compress_iter_if #(.WORD_W(64)) if64 ();

    sha2_compress_iter #(.WORD_W(32), .ROUNDS(64), .CNT_W(7)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if32)
    );

    sha2_compress_iter #(.WORD_W(64), .ROUNDS(80), .CNT_W(7)) dut64 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if64)
    );

    logic [31:0] sig_x, sig0_y, sig1_y;
    sha2_big_sigma #(.WORD_W(32), .R0(2), .R1(13), .R2(22)) u_s0 (.x(sig_x), .y(sig0_y));
    sha2_big_sigma #(.WORD_W(32), .R0(6), .R1(11), .R2(25)) u_s1 (.x(sig_x), .y(sig1_y));

    int n_checks = 0;
    int n_errors = 0;

    logic [511:0] exp_q [$];
    logic [31:0]  w256 [64];
    logic [63:0]  w512 [80];
    logic [63:0]  k512 [80];

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // First 64 fraction bits of cbrt(p): integer cube root of p*2^192
    function automatic logic [63:0] cbrt_frac(input int p);
        logic [255:0] n, lo, hi, mid;
        n  = 256'(p) << 192;
        lo = '0;
        hi = 256'd1 << 68;
        while (hi - lo > 1) begin
            mid = (lo + hi) >> 1;
            if (mid * mid * mid <= n) lo = mid;
            else hi = mid;
        end
        return lo[63:0];
    endfunction

    task automatic build_tables();
        int cnt = 0;
        int cand = 2;
        while (cnt < 80) begin
            bit is_p = 1'b1;
            for (int d = 2; d * d <= cand; d++) if (cand % d == 0) is_p = 1'b0;
            if (is_p) begin
                k512[cnt] = cbrt_frac(cand);
                cnt++;
            end
            cand++;
        end
        for (int t = 0; t < 16; t++) begin
            w256[t] = '0;
            w512[t] = '0;
        end
        w256[0]  = 32'h61626380;
        w256[15] = 32'h18;
        w512[0]  = 64'h6162638000000000;
        w512[15] = 64'h18;
        for (int t = 16; t < 64; t++) begin
            logic [31:0] s0, s1;
            s0 = rotr32(w256[t-15], 7) ^ rotr32(w256[t-15], 18) ^ (w256[t-15] >> 3);
            s1 = rotr32(w256[t-2], 17) ^ rotr32(w256[t-2], 19) ^ (w256[t-2] >> 10);
            w256[t] = s1 + w256[t-7] + s0 + w256[t-16];
        end
        for (int t = 16; t < 80; t++) begin
            logic [63:0] s0, s1;
            s0 = rotr64(w512[t-15], 1) ^ rotr64(w512[t-15], 8) ^ (w512[t-15] >> 7);
            s1 = rotr64(w512[t-2], 19) ^ rotr64(w512[t-2], 61) ^ (w512[t-2] >> 6);
            w512[t] = s1 + w512[t-7] + s0 + w512[t-16];
        end
    endtask

    task automatic drive(input bit sel, input logic st, input logic [511:0] hin,
                         input logic v, input logic [63:0] w, input logic [63:0] k);
        if (sel) begin
            if64.start = st; if64.hash_in = hin; if64.wk_valid = v; if64.w_in = w; if64.k_in = k;
        end else begin
            if32.start = st; if32.hash_in = hin[255:0]; if32.wk_valid = v;
            if32.w_in = w[31:0]; if32.k_in = k[31:0];
        end
    endtask

    function automatic logic get_done(input bit sel);
        return sel ? if64.done : if32.done;
    endfunction

    function automatic logic get_ready(input bit sel);
        return sel ? if64.wk_ready : if32.wk_ready;
    endfunction

    function automatic logic get_busy(input bit sel);
        return sel ? if64.busy : if32.busy;
    endfunction

    function automatic logic [511:0] get_hash(input bit sel);
        return sel ? if64.hash_out : {256'b0, if32.hash_out};
    endfunction

    // One "abc" block: stall_pct = % of cycles with wk_valid low, inj_at = beat
    // index where a stray start is pulsed, rst_at = beat index where reset hits
    task automatic run_block(input bit sel, input int stall_pct, input int inj_at,
                             input int rst_at, input string name);
        int rounds = sel ? 80 : 64;
        int idx = 0, cyc = 0, stalls = 0, ndone = 0, post = 0;
        bit fire = 1'b0, seen = 1'b0, injected = 1'b0;
        logic [511:0] garbage = {8{64'h0123456789abcdef}};
        logic v, st;
        logic [63:0] w, k;

        @(negedge clk);
        drive(sel, 1'b1, sel ? IV512 : {256'b0, IV256}, 1'b0, '0, '0);
        exp_q.push_back(sel ? D512 : {256'b0, D256});
        while (1) begin
            @(negedge clk);
            cyc++;
            if (fire) idx++;
            fire = 1'b0;
            if (get_done(sel)) begin
                ndone++;
                seen = 1'b1;
                if (exp_q.size() == 0) begin
                    check_eq({name, " spurious_done"}, 1, 0);
                end else begin
                    check_eq({name, " digest"}, get_hash(sel), exp_q.pop_front());
                    check_eq({name, " latency"}, cyc, 2 + rounds + stalls);
                end
            end
            if (seen) begin
                post++;
                if (post > 4) break;
            end
            if (cyc > 800) begin
                check_eq({name, " timeout_no_done"}, 0, 1);
                break;
            end
            if (rst_at >= 0 && idx == rst_at) begin
                rst_n = 1'b0;
                drive(sel, 1'b0, garbage, 1'b0, '0, '0);
                #1;
                check_eq({name, " rst_busy"}, get_busy(sel), 0);
                check_eq({name, " rst_done"}, get_done(sel), 0);
                check_eq({name, " rst_ready"}, get_ready(sel), 0);
                check_eq({name, " rst_hash"}, get_hash(sel), 0);
                exp_q.delete();
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            st = (inj_at >= 0 && idx == inj_at && !injected);
            if (st) injected = 1'b1;
            v = ($urandom_range(99) >= stall_pct);
            if (idx < rounds) begin
                w = sel ? w512[idx] : {32'b0, w256[idx]};
                k = sel ? k512[idx] : {32'b0, k512[idx][63:32]};
            end else begin
                w = {$urandom, $urandom};
                k = {$urandom, $urandom};
            end
            drive(sel, st, garbage, v, w, k);
            fire = v && get_ready(sel);
            if (get_ready(sel) && !v) stalls++;
        end
        drive(sel, 1'b0, garbage, 1'b0, '0, '0);
        if (rst_at < 0) check_eq({name, " done_count"}, ndone, 1);
        $display("block %s: cycles=%0d stalls=%0d dones=%0d", name, cyc, stalls, ndone);
    endtask

    initial begin
        build_tables();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, '0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, '0, 1'b0, '0, '0);

        sig_x = 32'h00000001;
        #1;
        check_eq("sigma0_one", sig0_y, 32'h40080400);
        check_eq("sigma1_one", sig1_y, 32'h04200080);
        sig_x = 32'hffffffff;
        #1;
        check_eq("sigma0_ones", sig0_y, 32'hffffffff);
        check_eq("sigma1_ones", sig1_y, 32'hffffffff);

        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check_eq("reset_busy", get_busy(s[0]), 0);
            check_eq("reset_ready", get_ready(s[0]), 0);
            check_eq("reset_done", get_done(s[0]), 0);
            check_eq("reset_hash", get_hash(s[0]), 0);
        end
        rst_n = 1'b1;

        run_block(1'b0, 0,  -1, -1, "sha256_abc");
        run_block(1'b1, 0,  -1, -1, "sha512_abc");
        run_block(1'b0, 50, -1, -1, "sha256_stall");
        run_block(1'b0, 0,  10, -1, "sha256_start_busy");
        run_block(1'b0, 30, 10, -1, "sha256_start_busy_stall");
        run_block(1'b0, 0,  -1, 30, "sha256_reset_mid");
        run_block(1'b0, 0,  -1, -1, "sha256_after_reset");
        run_block(1'b1, 40, -1, -1, "sha512_stall");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
